// File: rtl/dft_pkg.sv
// Shared types and sizing for the DFT sequencer, its MAC datapath and the benches.
package dft_pkg;

  localparam int N_PTS    = 8;
  localparam int SAMPLE_W = 4;
  localparam int RES_W    = 64;
  localparam int IDX_W    = $clog2(N_PTS);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_PTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RES,
    S_OUT,
    S_DONE
  } seq_state_t;

  // Element 0 (least significant nibble) is x[0]
  typedef logic [N_PTS-1:0][SAMPLE_W-1:0] sample_arr_t;

endpackage

// File: rtl/dft_sequencer_if.sv
// MAC beat channel, MAC result return and downstream bin-result channel.
interface dft_sequencer_if;
  import dft_pkg::*;

  logic                mac_valid;
  logic                mac_ready;
  logic [SAMPLE_W-1:0] mac_sample;
  logic [IDX_W-1:0]    mac_tw_idx;
  logic                mac_first;
  logic                mac_last;

  logic                res_valid;
  logic [RES_W-1:0]    res_re;
  logic [RES_W-1:0]    res_im;

  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_bin;
  logic [RES_W-1:0]    out_re;
  logic [RES_W-1:0]    out_im;

  modport master (
    output mac_valid, mac_sample, mac_tw_idx, mac_first, mac_last,
    input  mac_ready,
    input  res_valid, res_re, res_im,
    output out_valid, out_bin, out_re, out_im,
    input  out_ready
  );

  modport slave (
    input  mac_valid, mac_sample, mac_tw_idx, mac_first, mac_last,
    output mac_ready,
    output res_valid, res_re, res_im,
    input  out_valid, out_bin, out_re, out_im,
    output out_ready
  );

endinterface

// File: rtl/dft_tw_index.sv
// Combinational twiddle index (k*n) mod N_PTS; also usable for twiddle ROM addressing.
module dft_tw_index
  import dft_pkg::*;
(
  input  logic [IDX_W-1:0] k,
  input  logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] tw_idx
);

  // N_PTS is a power of two, so the modulo is just the low bits of the full product
  assign tw_idx = IDX_W'(k * n);

endmodule

// File: rtl/dft_sequencer.sv
// Walks bins k and samples n of an N-point DFT, feeding a shared complex MAC and
// forwarding each bin's result downstream.
module dft_sequencer
  import dft_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  sample_arr_t     samples,
  output logic            busy,
  output logic            done,
  output logic            err_unexp_res,
  dft_sequencer_if.master bus
);

  seq_state_t       state;
  sample_arr_t      sbuf;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] n_nxt;
  logic [IDX_W-1:0] tw_nxt;

  assign n_nxt = n + IDX_W'(1);
  assign busy  = (state != S_IDLE);

  // Twiddle index for the beat that follows the one currently presented
  dft_tw_index u_tw (
    .k      (k),
    .n      (n_nxt),
    .tw_idx (tw_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      sbuf           <= '0;
      k              <= '0;
      n              <= '0;
      done           <= 1'b0;
      err_unexp_res  <= 1'b0;
      bus.mac_valid  <= 1'b0;
      bus.mac_sample <= '0;
      bus.mac_tw_idx <= '0;
      bus.mac_first  <= 1'b0;
      bus.mac_last   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_bin    <= '0;
      bus.out_re     <= '0;
      bus.out_im     <= '0;
    end else if (abort) begin
      state         <= S_IDLE;
      bus.mac_valid <= 1'b0;
      bus.out_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.res_valid && (state != S_WAIT_RES))
        err_unexp_res <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            sbuf           <= samples;
            k              <= '0;
            n              <= '0;
            err_unexp_res  <= 1'b0;
            bus.mac_valid  <= 1'b1;
            bus.mac_sample <= samples[0];
            bus.mac_tw_idx <= '0;
            bus.mac_first  <= 1'b1;
            bus.mac_last   <= 1'b0;
            state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (bus.mac_ready) begin
            n <= n_nxt;
            if (bus.mac_last) begin
              bus.mac_valid <= 1'b0;
              bus.mac_first <= 1'b0;
              bus.mac_last  <= 1'b0;
              state         <= S_WAIT_RES;
            end else begin
              bus.mac_sample <= sbuf[n_nxt];
              bus.mac_tw_idx <= tw_nxt;
              bus.mac_first  <= 1'b0;
              bus.mac_last   <= (n_nxt == IDX_MAX);
            end
          end
        end

        S_WAIT_RES: begin
          if (bus.res_valid) begin
            bus.out_re    <= bus.res_re;
            bus.out_im    <= bus.res_im;
            bus.out_bin   <= k;
            bus.out_valid <= 1'b1;
            state         <= S_OUT;
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (k == IDX_MAX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // Next bin restarts at x[0], whose twiddle index is always 0
              k              <= k + IDX_W'(1);
              n              <= '0;
              bus.mac_valid  <= 1'b1;
              bus.mac_sample <= sbuf[0];
              bus.mac_tw_idx <= '0;
              bus.mac_first  <= 1'b1;
              bus.mac_last   <= 1'b0;
              state          <= S_ISSUE;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_sequencer.sv
// Bench for dft_sequencer: behavioural MAC/downstream model, per-bin scoreboard and a vector table.
module tb_dft_sequencer;
  import dft_pkg::*;

  typedef struct {
    int     bin;
    longint re;
    longint im;
  } sb_t;

  typedef struct {
    logic [31:0] x;
    int          rdy_mode;   // 0: mac_ready high, 1: alternating
    int          stall_bin;  // bin whose output is held off for 5 cycles, -1 none
    int          poke_bin;   // bin at which start + new samples are pulsed, -1 none
    int          abort_bin;  // bin in which abort is pulsed at beat 2, -1 none
    int          exp_beats;
    int          exp_bins;
    int          exp_done;
    int          exp_stall;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             inj_res = 1'b0;
  logic             model_res = 1'b0;
  logic             mac_ready = 1'b1;
  logic             out_ready = 1'b1;
  sample_arr_t      samples = '0;
  logic [RES_W-1:0] model_re = '0;
  logic [RES_W-1:0] model_im = '0;
  logic             busy, done, err_unexp_res;

  int n_cmp = 0, n_fail = 0;
  int beats = 0, beat_n = 0, bins_out = 0, done_cnt = 0, stall_seen = 0;
  int stall_left = 0, res_cnt = 0, rdy_mode = 0, stall_bin = -1;
  longint acc_re = 0, acc_im = 0;
  logic [31:0] exp_x = '0;
  sb_t sb_q[$];
  vec_t vecs[5];

  logic prev_stall = 0, prev_out = 0, prev_res = 0, prev_fin = 0;
  logic [SAMPLE_W-1:0] h_sample;
  logic [IDX_W-1:0]    h_tw, h_bin;
  logic                h_first, h_last;
  logic [RES_W-1:0]    h_re, h_im;

  dft_sequencer_if bus();

  assign bus.mac_ready = mac_ready;
  assign bus.out_ready = out_ready;
  assign bus.res_valid = model_res | inj_res;
  assign bus.res_re    = model_re;
  assign bus.res_im    = model_im;

  dft_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .samples       (samples),
    .busy          (busy),
    .done          (done),
    .err_unexp_res (err_unexp_res),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference bin values for the MAC model: re = sum x[n]*(tw+1), im = sum x[n]*tw^2
  function automatic longint exp_re(input logic [31:0] x, input int k);
    longint s = 0;
    for (int i = 0; i < N_PTS; i++)
      s += longint'(x[i*SAMPLE_W +: SAMPLE_W]) * longint'(((k * i) % N_PTS) + 1);
    return s;
  endfunction

  function automatic longint exp_im(input logic [31:0] x, input int k);
    longint s = 0;
    longint t;
    for (int i = 0; i < N_PTS; i++) begin
      t = longint'((k * i) % N_PTS);
      s += longint'(x[i*SAMPLE_W +: SAMPLE_W]) * t * t;
    end
    return s;
  endfunction

  // Runs at each falling edge: checks held outputs, drives the model inputs for the
  // coming rising edge, then scores the handshakes that edge will complete.
  task automatic mon_step();
    sb_t e;
    if (!rst_n) begin
      prev_stall = 0; prev_out = 0; prev_res = 0; prev_fin = 0;
      res_cnt = 0; model_res = 0; mac_ready = 1; out_ready = 1;
      sb_q.delete();
      return;
    end
    if (prev_stall) begin
      check("mac_hold_valid", bus.mac_valid, 1);
      check("mac_hold_sample", bus.mac_sample, h_sample);
      check("mac_hold_tw", bus.mac_tw_idx, h_tw);
      check("mac_hold_first", bus.mac_first, h_first);
      check("mac_hold_last", bus.mac_last, h_last);
    end
    if (prev_out) begin
      check("out_hold_valid", bus.out_valid, 1);
      check("out_hold_bin", bus.out_bin, h_bin);
      check("out_hold_re", bus.out_re, h_re);
      check("out_hold_im", bus.out_im, h_im);
    end
    if (prev_res) check("res_to_out_lat", bus.out_valid, 1);
    if (prev_fin) check("out_to_done_lat", done, 1);
    if (done) done_cnt++;
    if (bus.out_valid) check("no_beat_while_out", bus.mac_valid, 0);

    model_res = 0;
    if (res_cnt > 0) begin
      res_cnt--;
      if (res_cnt == 0) begin
        model_res = 1; model_re = acc_re; model_im = acc_im;
      end
    end
    mac_ready = (rdy_mode == 0) ? 1'b1 : ~mac_ready;
    if (stall_bin >= 0 && bus.out_valid && int'(bus.out_bin) == stall_bin && stall_left > 0) begin
      out_ready = 0; stall_left--;
    end else begin
      out_ready = 1;
    end
    if (bus.out_valid && !out_ready) stall_seen++;

    prev_res   = model_res;
    prev_stall = bus.mac_valid && !mac_ready && !abort;
    prev_out   = bus.out_valid && !out_ready && !abort;
    prev_fin   = bus.out_valid && out_ready && !abort && (bus.out_bin == IDX_W'(N_PTS - 1));
    h_sample = bus.mac_sample; h_tw = bus.mac_tw_idx; h_first = bus.mac_first; h_last = bus.mac_last;
    h_bin = bus.out_bin; h_re = bus.out_re; h_im = bus.out_im;

    if (start && !busy && !abort) begin
      exp_x = samples;
      sb_q.delete();
      beats = 0; beat_n = 0; bins_out = 0; done_cnt = 0; stall_seen = 0; stall_left = 5;
      for (int k = 0; k < N_PTS; k++) begin
        e.bin = k; e.re = exp_re(samples, k); e.im = exp_im(samples, k);
        sb_q.push_back(e);
      end
    end
    if (bus.mac_valid && mac_ready && !abort) begin
      check("beat_sample", bus.mac_sample, exp_x[beat_n*SAMPLE_W +: SAMPLE_W]);
      check("beat_tw", bus.mac_tw_idx, (bins_out * beat_n) % N_PTS);
      check("beat_first", bus.mac_first, beat_n == 0);
      check("beat_last", bus.mac_last, beat_n == N_PTS - 1);
      if (bus.mac_first) begin acc_re = 0; acc_im = 0; end
      acc_re += longint'(bus.mac_sample) * (longint'(bus.mac_tw_idx) + 1);
      acc_im += longint'(bus.mac_sample) * longint'(bus.mac_tw_idx) * longint'(bus.mac_tw_idx);
      if (bus.mac_last) res_cnt = 2;
      beats++; beat_n++;
    end
    if (bus.out_valid && out_ready && !abort) begin
      check("beats_per_bin", beat_n, N_PTS);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("out_bin", bus.out_bin, e.bin);
        check("out_re", bus.out_re, e.re);
        check("out_im", bus.out_im, e.im);
      end
      bins_out++; beat_n = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bit poked = 0;
    bit aborted = 0;
    bit finished = 0;
    rdy_mode = v.rdy_mode; stall_bin = v.stall_bin;
    samples = v.x; start = 1;
    tick();
    start = 0;
    check("start_mac_valid", bus.mac_valid, 1);
    check("start_busy", busy, 1);
    check("start_err_clr", err_unexp_res, 0);
    for (int c = 0; c < 3000; c++) begin
      start = 0;
      if (done_cnt != 0) begin finished = 1; break; end
      if (v.poke_bin >= 0 && !poked && bins_out == v.poke_bin) begin
        start = 1; samples = '1; poked = 1;
      end
      if (v.abort_bin >= 0 && bins_out == v.abort_bin && beat_n == 2) begin
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_mac_valid", bus.mac_valid, 0);
        check("abort_out_valid", bus.out_valid, 0);
        aborted = 1; finished = 1;
        break;
      end
      tick();
    end
    start = 0;
    check("run_finished", finished, 1);
    repeat (4) tick();
    check("total_beats", beats, v.exp_beats);
    check("bins_out", bins_out, v.exp_bins);
    check("done_pulses", done_cnt, v.exp_done);
    check("out_stall_cycles", stall_seen, v.exp_stall);
    check("sb_left", sb_q.size(), N_PTS - v.exp_bins);
    check("idle_after_run", busy, 0);
  endtask

  initial begin
    bit hit;
    vecs[0] = '{32'h0000_0237, 0, -1, -1, -1, 64, 8, 1, 0};
    vecs[1] = '{32'h0000_0237, 1, -1, -1, -1, 64, 8, 1, 0};
    vecs[2] = '{32'h0000_0237, 0,  2, -1, -1, 64, 8, 1, 5};
    vecs[3] = '{32'h9C5A_13F6, 1, -1,  4, -1, 64, 8, 1, 0};
    vecs[4] = '{32'h0000_0237, 0, -1, -1,  4, 34, 4, 0, 0};

    #2 rst_n = 0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_unexp_res, 0);
    check("rst_mac_valid", bus.mac_valid, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_re", bus.out_re, 0);
    check("rst_out_bin", bus.out_bin, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Unexpected result while idle after the abort
    check("err_after_abort", err_unexp_res, 0);
    inj_res = 1;
    tick();
    inj_res = 0;
    check("err_set_idle", err_unexp_res, 1);
    repeat (3) tick();
    check("err_sticky", err_unexp_res, 1);

    // Asynchronous reset in the middle of bin 3, beat 5
    rdy_mode = 0; stall_bin = -1;
    samples = 32'h0000_0237; start = 1;
    tick();
    start = 0;
    check("restart_err_clr", err_unexp_res, 0);
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      if (bins_out == 3 && beat_n == 5) begin hit = 1; break; end
      tick();
    end
    check("reach_k3_n5", hit, 1);
    check("k3_n5_tw", bus.mac_tw_idx, 7);
    rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_mac_valid", bus.mac_valid, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_re", bus.out_re, 0);
    repeat (2) tick();
    rst_n = 1;
    repeat (2) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_mac_valid", bus.mac_valid, 0);

    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
